vend_txn_controller: RTL
========================

# vend_txn_controller

Transaction sequencer for the coin-operated vending datapath. It accepts coin events from the coin acceptor, accumulates credit, and compares it against a configurable price on a product select. It then drives the dispense actuator and the change hopper through req/ack handshakes, and refunds credit on cancel or inactivity timeout. It sits between the coin/button front end and the dispense and change mechanisms.

## Interface
- PRICE, 3: product price in credit units (1 unit = nickel); 1..MAX_CREDIT
- MAX_CREDIT, 15: credit ceiling; must fit CREDIT_W
- CREDIT_W, 4: credit register width
- TIMEOUT, 255: idle cycles in CREDIT before auto-refund; >=2
- TIMER_W, 8: timer width; must hold TIMEOUT

Ports:
- clk  in  1  clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- coin_valid  in  1  coin event present
- coin_type  in  1  0 = nickel (+1), 1 = dime (+2)
- coin_ready  out  1  controller can accept a coin; handshake = coin_valid && coin_ready
- select  in  1  purchase request, level-sampled each cycle
- cancel  in  1  refund request, level-sampled each cycle
- disp_req  out  1  dispense one product
- disp_ack  in  1  dispense complete
- chg_req  out  1  return one nickel
- chg_ack  in  1  one nickel returned
- credit  out  CREDIT_W  current credit, registered
- busy  out  1  state is DISPENSE or CHANGE
- err  out  1  one-cycle pulse: select with insufficient credit

## Operation
- States: IDLE, CREDIT, DISPENSE, CHANGE. The state register and credit are registered.
- disp_req = (state == DISPENSE), chg_req = (state == CHANGE), busy = disp_req | chg_req (Moore decode).
- coin_ready = (state is IDLE or CREDIT) && credit <= MAX_CREDIT-2. It depends only on registered state and credit.
- Accepted coin: credit_next = credit + value. Timer clears to 0.
- IDLE: credit is 0. An accepted coin moves to CREDIT. select with no coin pulses err. cancel is ignored.
- CREDIT: evaluation uses eff = credit + accepted coin value in that same cycle. Priority is cancel > select > timeout.
  - cancel -> CHANGE, credit = eff.
  - select with eff >= PRICE -> DISPENSE, credit = eff - PRICE.
  - select with eff < PRICE -> err = 1 for one cycle; stay in CREDIT with credit = eff.
  - Otherwise, no coin increments the timer; timer == TIMEOUT-1 -> CHANGE, timer cleared.
- DISPENSE: hold until disp_ack is sampled high. Then go to CHANGE if credit != 0, else IDLE. select, cancel and coins are ignored (coin_ready = 0).
- CHANGE: each cycle with chg_ack = 1 decrements credit by 1. The ack that takes credit 1 -> 0 moves to IDLE. chg_ack is ignored outside CHANGE.
- Arithmetic: credit never exceeds MAX_CREDIT, guaranteed by coin_ready gating. Subtraction is only performed when eff >= PRICE, so there is no underflow and no wrap.
- disp_ack outside DISPENSE is ignored.

## Timing
- Reset values: state IDLE, credit 0, timer 0, coin_ready 1, disp_req 0, chg_req 0, busy 0, err 0.
- Reset mid-transaction (any state) returns everything to reset values on the next edge. disp_req and chg_req drop, and outstanding credit is discarded.
- select sampled at edge N -> disp_req high from cycle N+1.
- disp_ack sampled at edge M -> disp_req low from M+1. chg_req is high from M+1 if change is due.
- The last chg_ack at edge K -> chg_req low and credit 0 from K+1.
- Back-to-back acks in consecutive cycles are legal: one nickel per ack-cycle. A held ack counts every cycle.
- err is high exactly in cycle N+1 after the offending select at edge N.
- Timeout: with no coin after the last accepted coin at edge C, CHANGE is entered at edge C+TIMEOUT.
- Transaction latency: exact payment = 1 cycle + dispense ack latency. Overpayment adds one cycle per nickel of change plus the ack latency.

## Test plan
- Reset: assert reset for 2 cycles with disp_ack and chg_ack high -> all outputs at reset values, coin_ready = 1, credit = 0.
- Exact pay (PRICE = 3): dime then nickel -> credit 2, then 3. select -> disp_req the next cycle. disp_ack 4 cycles later -> IDLE, credit 0, chg_req never asserted.
- Overpay with change: two dimes (credit 4), select -> credit 1, DISPENSE. After disp_ack -> chg_req = 1. One chg_ack -> credit 0, IDLE, chg_req low the next cycle.
- Insufficient and same-cycle coin: nickel then select -> err pulse, credit 1, state CREDIT. Then dime with select in the same cycle -> eff 3, dispense, no err.
- Timeout and cancel (TIMEOUT = 8): one dime then idle -> CHANGE exactly 8 cycles after the coin, and 2 chg_acks refund it. Separately, nickel + cancel + select in the same cycle -> CHANGE, credit 1, no disp_req.
- Backpressure and reset: credit 13 -> coin_ready = 1. Add a nickel -> credit 14, coin_ready = 0, and a coin_valid there leaves credit unchanged. Assert reset during DISPENSE -> disp_req 0 and credit 0 the next cycle.

Source files
------------

// File: rtl/vend_txn_controller.sv
// vend_txn_controller
// Coin-operated vending transaction sequencer. Accumulates coin credit,
// checks it against PRICE on select, then drives the dispense and change
// mechanisms through req/ack handshakes. Credit is refunded one nickel per
// change ack on cancel or after an inactivity timeout. All outputs are
// registered; the request/busy/ready outputs are computed from the next
// state so that they line up cycle-for-cycle with a Moore decode of the
// state register.

module vend_txn_controller #(
  parameter int PRICE      = 3,
  parameter int MAX_CREDIT = 15,
  parameter int CREDIT_W   = 4,
  parameter int TIMEOUT    = 255,
  parameter int TIMER_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic                coin_type,
  output logic                coin_ready,
  input  logic                select,
  input  logic                cancel,
  output logic                disp_req,
  input  logic                disp_ack,
  output logic                chg_req,
  input  logic                chg_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CREDIT   = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  // Price in both the credit width and the widened "effective credit" width.
  localparam logic [CREDIT_W:0]   LP_PRICE_E  = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] LP_PRICE_C  = CREDIT_W'(PRICE);
  // A dime must still fit under the ceiling, so coins are refused above this.
  localparam logic [CREDIT_W-1:0] LP_RDY_MAX  = CREDIT_W'(MAX_CREDIT - 2);
  localparam logic [TIMER_W-1:0]  LP_TMO_LAST = TIMER_W'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit_next;
  logic [TIMER_W-1:0]  r_timer;
  logic [TIMER_W-1:0]  w_timer_next;
  logic                w_err_next;

  logic                r_coin_ready;
  logic                r_disp_req;
  logic                r_chg_req;
  logic                r_busy;
  logic                r_err;

  logic                w_coin_acc;
  logic [CREDIT_W:0]   w_coin_val;
  logic [CREDIT_W:0]   w_eff;
  logic [CREDIT_W-1:0] w_eff_c;
  logic [CREDIT_W-1:0] w_eff_sub;

  // Evaluation result for a cycle spent in (or entering) the credit phase.
  state_t              w_ev_state;
  logic [CREDIT_W-1:0] w_ev_credit;
  logic [TIMER_W-1:0]  w_ev_timer;
  logic                w_ev_err;

  // Coins are accepted only while ready and below the ceiling margin.
  function automatic logic f_coin_ready(input state_t s, input logic [CREDIT_W-1:0] c);
    return ((s == S_IDLE) || (s == S_CREDIT)) && (c <= LP_RDY_MAX);
  endfunction

  // Coin value and effective credit including a coin accepted this cycle.
  always_comb begin
    w_coin_acc = coin_valid & r_coin_ready;
    if (w_coin_acc) begin
      w_coin_val = coin_type ? (CREDIT_W+1)'(2) : (CREDIT_W+1)'(1);
    end else begin
      w_coin_val = '0;
    end
    w_eff     = {1'b0, r_credit} + w_coin_val;
    w_eff_c   = w_eff[CREDIT_W-1:0];
    w_eff_sub = w_eff_c - LP_PRICE_C;
  end

  // Credit-phase decision: cancel beats select beats the inactivity timer.
  always_comb begin
    w_ev_state  = S_CREDIT;
    w_ev_credit = r_credit;
    w_ev_timer  = r_timer;
    w_ev_err    = 1'b0;
    if (cancel) begin
      w_ev_state  = S_CHANGE;
      w_ev_credit = w_eff_c;
      w_ev_timer  = '0;
    end else if (select) begin
      if (w_eff >= LP_PRICE_E) begin
        w_ev_state  = S_DISPENSE;
        w_ev_credit = w_eff_sub;
        w_ev_timer  = '0;
      end else begin
        w_ev_state  = S_CREDIT;
        w_ev_credit = w_eff_c;
        w_ev_err    = 1'b1;
        // A coin arriving with the failed select still restarts the timer.
        w_ev_timer  = w_coin_acc ? '0 : r_timer;
      end
    end else if (w_coin_acc) begin
      w_ev_state  = S_CREDIT;
      w_ev_credit = w_eff_c;
      w_ev_timer  = '0;
    end else if (r_timer == LP_TMO_LAST) begin
      w_ev_state  = S_CHANGE;
      w_ev_credit = r_credit;
      w_ev_timer  = '0;
    end else begin
      w_ev_state  = S_CREDIT;
      w_ev_credit = r_credit;
      w_ev_timer  = r_timer + TIMER_W'(1);
    end
  end

  // Next-state, next-credit and timer logic for the transaction FSM.
  always_comb begin
    w_state_next  = r_state;
    w_credit_next = r_credit;
    w_timer_next  = '0;
    w_err_next    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // With a coin in hand the idle cycle is judged like a credit cycle,
        // so a coin together with cancel/select takes effect immediately.
        if (w_coin_acc) begin
          w_state_next  = w_ev_state;
          w_credit_next = w_ev_credit;
          w_timer_next  = '0;
          w_err_next    = w_ev_err;
        end else if (select) begin
          w_err_next = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_CREDIT: begin
        w_state_next  = w_ev_state;
        w_credit_next = w_ev_credit;
        w_timer_next  = w_ev_timer;
        w_err_next    = w_ev_err;
      end
      S_DISPENSE: begin
        if (disp_ack) begin
          w_state_next = (r_credit != '0) ? S_CHANGE : S_IDLE;
        end else begin
          w_state_next = S_DISPENSE;
        end
      end
      S_CHANGE: begin
        if (chg_ack) begin
          if (r_credit <= CREDIT_W'(1)) begin
            w_state_next  = S_IDLE;
            w_credit_next = '0;
          end else begin
            w_credit_next = r_credit - CREDIT_W'(1);
          end
        end else begin
          w_state_next = S_CHANGE;
        end
      end
      default: begin
        w_state_next  = S_IDLE;
        w_credit_next = '0;
      end
    endcase
  end

  // State, credit and timer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_credit <= '0;
      r_timer  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_credit <= w_credit_next;
      r_timer  <= w_timer_next;
    end
  end

  // Registered outputs decoded from the next state so they track r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_coin_ready <= 1'b1;
      r_disp_req   <= 1'b0;
      r_chg_req    <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_coin_ready <= f_coin_ready(w_state_next, w_credit_next);
      r_disp_req   <= (w_state_next == S_DISPENSE);
      r_chg_req    <= (w_state_next == S_CHANGE);
      r_busy       <= (w_state_next == S_DISPENSE) || (w_state_next == S_CHANGE);
      r_err        <= w_err_next;
    end
  end

  assign coin_ready = r_coin_ready;
  assign disp_req   = r_disp_req;
  assign chg_req    = r_chg_req;
  assign busy       = r_busy;
  assign err        = r_err;
  assign credit     = r_credit;

endmodule
